// File: rtl/riscv_dbg_pkg.sv
// Shared definitions for the debug-value UART reporter: sync byte, frame
// length, serializer state encoding and the frame byte selector.
// Latency: n/a (constants and a pure function). Backpressure: n/a.
package riscv_dbg_pkg;

  // First byte of every frame, used by the receiver to find frame alignment.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Bytes per frame: sync, value[15:8], value[7:0].
  localparam int unsigned FRAME_BYTES = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Byte 'idx' of the frame carrying 'value'.
  function automatic logic [7:0] frame_byte(input logic [15:0] value,
                                            input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = SYNC_BYTE;
      2'd1:    b = value[15:8];
      default: b = value[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART byte serializer: 1 start bit, 8 data bits LSB first, 1 stop bit,
// each held CLKS_PER_BIT cycles. Latency: tx goes low on the edge that
// samples start. Backpressure: start is only honoured in IDLE or on the
// final stop-bit cycle (when done is high), giving gapless byte chaining.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        request to send byte_in (sampled in IDLE or with done)
//   byte_in      byte to serialize, captured on the accepting edge
//   tx           serial line, idle high
//   done         high on the last cycle of the stop bit
//   state        current serializer state (IDLE means line free)
module uart_tx_byte
  import riscv_dbg_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       done,
  output tx_state_e  state
);

  localparam int unsigned   CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CYC = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          bit_end;

  assign bit_end = (cyc_q == LAST_CYC);
  assign state   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START;
          cyc_d   = '0;
          shreg_d = byte_in;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cyc_d   = '0;
          bit_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cyc_d   = '0;
          // Shift right so shreg_q[0] is always the bit on the line.
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          done  = 1'b1;
          cyc_d = '0;
          // Chaining straight into START avoids an idle cycle between the
          // bytes of one frame.
          if (start) begin
            state_d = START;
            shreg_d = byte_in;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is a pure decode of registered state, so it changes on the
  // same edge that changes state and snaps high on reset.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shreg_q[0];
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/test_value_uart_tx.sv
// Reports changes of a processor debug value over UART as 3-byte frames
// (A5, value[15:8], value[7:0]). Latency: change sampled at edge k gives the
// TX start bit from edge k+1. Backpressure: none upstream; one pending slot,
// newer changes overwrite it and bump a saturating drop counter.
// Ports:
//   CLK          system clock, rising edge
//   RESET        asynchronous active-low reset
//   test_value   monitored value, synchronous to CLK
//   TX           UART line, idle high
//   busy         high while a frame is on the line
//   dropped_cnt  saturating count of overwritten pending values
module test_value_uart_tx
  import riscv_dbg_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned VALUE_WIDTH  = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [VALUE_WIDTH-1:0] test_value,
  output logic                   TX,
  output logic                   busy,
  output logic [7:0]             dropped_cnt
);

  logic [VALUE_WIDTH-1:0] last_value;
  logic [VALUE_WIDTH-1:0] pending;
  logic                   pending_valid;
  logic [15:0]            frame_buf;
  logic [1:0]             byte_idx;
  logic [7:0]             drop_q;

  tx_state_e state;
  logic      change;
  logic      take;
  logic      advance;
  logic      start;
  logic      done;
  logic [7:0] byte_in;

  // last_value resets to 0, so a zero value after reset is not a change but
  // any nonzero value present at release is.
  assign change = (test_value != last_value);

  // A new frame begins whenever the line is free and something is waiting.
  assign take = (state == IDLE) && pending_valid;

  // Chain the next byte of the current frame on the final stop-bit cycle.
  assign advance = done && (byte_idx < 2'(FRAME_BYTES - 1));

  assign start   = take || advance;
  assign byte_in = frame_byte(frame_buf, take ? 2'd0 : byte_idx + 2'd1);

  assign busy        = (state != IDLE);
  assign dropped_cnt = drop_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_value    <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      frame_buf     <= '0;
      byte_idx      <= '0;
      drop_q        <= '0;
    end else begin
      last_value <= test_value;

      // A change on the take edge refills the slot just emptied, so it is
      // not a drop; only a change landing on a still-full slot counts.
      if (change) begin
        pending       <= test_value;
        pending_valid <= 1'b1;
        if (pending_valid && !take && (drop_q != 8'hFF)) begin
          drop_q <= drop_q + 8'd1;
        end
      end else if (take) begin
        pending_valid <= 1'b0;
      end

      // Frame contents are frozen at take; later activity cannot alter them.
      if (take) begin
        frame_buf <= 16'(pending);
        byte_idx  <= '0;
      end else if (advance) begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk    (CLK),
    .rst_n  (RESET),
    .start  (start),
    .byte_in(byte_in),
    .tx     (TX),
    .done   (done),
    .state  (state)
  );

endmodule

// File: tb/tb_test_value_uart_tx.sv
// Directed-sequence bench with randomized values for test_value_uart_tx at
// CLKS_PER_BIT=4: a line decoder rebuilds bytes from TX, and expected frames,
// timings and drop counts are derived from the frame format rules.
module tb_test_value_uart_tx;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 3 * 10 * CPB;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [15:0] test_value = '0;
  logic        TX;
  logic        busy;
  logic [7:0]  dropped_cnt;

  test_value_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .VALUE_WIDTH (16)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .test_value (test_value),
    .TX         (TX),
    .busy       (busy),
    .dropped_cnt(dropped_cnt)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         busy_runs[$];
  int         frame_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rxb(input int i);
    return (i >= 0 && i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic int rxt(input int i);
    return (i >= 0 && i < rx_t.size()) ? rx_t[i] : -1;
  endfunction

  function automatic logic [15:0] rnd_val(input logic [15:0] avoid);
    logic [15:0] v;
    do v = 16'($urandom_range(32'h0100, 32'hFFFF)); while (v == avoid);
    return v;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      step();
      k++;
    end
    if (rx_q.size() < n) chk("timeout_bytes", rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    int k = 0;
    while (quiet < 3 && k < budget) begin
      step();
      k++;
      quiet = (busy === 1'b0) ? quiet + 1 : 0;
    end
    if (quiet < 3) chk("timeout_idle", quiet, 3);
  endtask

  task automatic wait_cyc(input int target);
    int k = 0;
    while (cyc < target && k < 1000) begin
      step();
      k++;
    end
    if (cyc != target) chk("cyc_sync", cyc, target);
  endtask

  // Expected frame for value v: sync byte, high byte, low byte.
  task automatic check_frame(input string tag, input int base, input logic [15:0] v);
    chk({tag, "_sync"}, rxb(base), 32'h00A5);
    chk({tag, "_hi"},   rxb(base + 1), 32'(v / 256));
    chk({tag, "_lo"},   rxb(base + 2), 32'(v % 256));
  endtask

  // Line decoder: detects a start bit, samples each bit one cycle into its
  // CPB-cycle window and abandons the byte if reset is seen.
  initial begin : rx_mon
    logic [7:0] b;
    logic       stop_bit;
    bit         ok;
    int         c0;
    b = '0;
    stop_bit = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      if (RESET === 1'b1 && TX === 1'b0) begin
        c0 = cyc;
        ok = 1'b1;
        for (int j = 0; j < 9 && ok; j++) begin
          repeat ((j == 0) ? CPB + 1 : CPB) @(posedge CLK);
          #2;
          if (RESET !== 1'b1) ok = 1'b0;
          else if (j < 8) b[j] = TX;
          else stop_bit = TX;
        end
        if (ok) begin
          if (stop_bit === 1'b1) begin
            rx_q.push_back(b);
            rx_t.push_back(c0);
          end else begin
            frame_err++;
          end
          repeat (CPB - 2) @(posedge CLK);
        end else begin
          while (RESET !== 1'b1) @(posedge CLK);
        end
      end
    end
  end

  initial begin : busy_mon
    int run = 0;
    forever begin
      @(posedge CLK);
      #2;
      if (busy === 1'b1) run++;
      else begin
        if (run > 0) busy_runs.push_back(run);
        run = 0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "simulation did not complete");
  end

  initial begin : stim
    int          n;
    int          c0;
    int          m;
    int          base;
    logic [7:0]  drop_exp;
    logic [15:0] va, vb, vc, vd, ve, vf, last;

    RESET = 1'b0;
    test_value = '0;
    repeat (3) step();
    chk("rst_tx", TX, 1);
    chk("rst_busy", busy, 0);
    chk("rst_dropped", dropped_cnt, 0);

    // Zero at release is not a change.
    RESET = 1'b1;
    repeat (5) step();
    chk("idle_tx", TX, 1);
    chk("idle_busy", busy, 0);

    // Single change.
    busy_runs.delete(); rx_q.delete(); rx_t.delete();
    test_value = 16'h1234;
    n = cyc;
    wait_bytes(3, 200);
    check_frame("single", 0, 16'h1234);
    chk("single_latency", rxt(0), n + 2);
    wait_idle(50);
    chk("single_busy_len", (busy_runs.size() > 0) ? busy_runs[0] : -1, FRAME_CYC);
    chk("single_dropped", dropped_cnt, 0);
    drop_exp = 8'd0;

    // Overwrite of the pending slot while a frame is on the line.
    rx_q.delete(); rx_t.delete();
    va = rnd_val(16'h1234);
    test_value = va;
    repeat (12) step();
    test_value = 16'h0001; repeat (3) step();
    test_value = 16'h0002; repeat (3) step();
    test_value = 16'h0003;
    drop_exp = drop_exp + 8'd2;
    wait_bytes(6, 400);
    check_frame("ovw_first", 0, va);
    check_frame("ovw_second", 3, 16'h0003);
    chk("ovw_dropped", dropped_cnt, drop_exp);
    wait_idle(200);

    // Change lands in the final stop bit: one idle cycle, then a new frame.
    rx_q.delete(); rx_t.delete();
    vb = rnd_val(16'h0003);
    test_value = vb;
    c0 = cyc + 2;
    wait_cyc(c0 + FRAME_CYC - 4);
    vc = rnd_val(vb);
    test_value = vc;
    wait_cyc(c0 + FRAME_CYC);
    chk("b2b_idle_tx", TX, 1);
    chk("b2b_idle_busy", busy, 0);
    step();
    chk("b2b_restart_tx", TX, 0);
    chk("b2b_restart_busy", busy, 1);
    wait_bytes(6, 300);
    check_frame("b2b_first", 0, vb);
    check_frame("b2b_second", 3, vc);
    chk("b2b_second_start", rxt(3), c0 + FRAME_CYC + 1);
    wait_idle(200);

    // Change on the same edge as the frame take.
    rx_q.delete(); rx_t.delete();
    vd = rnd_val(vc);
    test_value = vd;
    n = cyc;
    step();
    ve = rnd_val(vd);
    test_value = ve;
    wait_bytes(6, 300);
    check_frame("simul_old", 0, vd);
    check_frame("simul_new", 3, ve);
    chk("simul_start0", rxt(0), n + 2);
    chk("simul_start1", rxt(3), n + 2 + FRAME_CYC + 1);
    chk("simul_dropped", dropped_cnt, drop_exp);
    wait_idle(200);

    // Reset in the middle of the data bits of the second byte.
    rx_q.delete(); rx_t.delete();
    vf = rnd_val(ve);
    test_value = vf;
    c0 = cyc + 2;
    wait_cyc(c0 + 55);
    RESET = 1'b0;
    #1;
    chk("midrst_tx", TX, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_dropped", dropped_cnt, 0);
    drop_exp = 8'd0;
    repeat (6) step();
    rx_q.delete(); rx_t.delete();
    RESET = 1'b1;
    m = cyc;
    wait_bytes(3, 200);
    check_frame("post_rst", 0, vf);
    chk("post_rst_latency", rxt(0), m + 2);
    wait_idle(200);

    // Saturation of the drop counter under continuous changes.
    rx_q.delete(); rx_t.delete();
    last = vf;
    for (int i = 0; i < 700; i++) begin
      last = rnd_val(last);
      test_value = last;
      step();
    end
    wait_idle(400);
    chk("sat_dropped", dropped_cnt, 8'hFF);
    base = rx_q.size() - 3;
    check_frame("sat_latest", base, last);
    chk("framing_errors", frame_err, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/test_value_uart_tx.md
TEST_VALUE_UART_TX -- requirements
Module: test_value_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, giving clock cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter VALUE_WIDTH, default 16, giving the width of the monitored test_value.
REQ-003 SHALL have port CLK  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port test_value  input  VALUE_WIDTH  processor debug value to be reported.
REQ-006 SHALL have port TX  output  1  UART serial line, idle high.
REQ-007 SHALL have port busy  output  1  high while a frame is being serialized.
REQ-008 SHALL have port dropped_cnt  output  8  saturating count of overwritten pending values.

Function
REQ-009 SHALL register last_value each edge; a change is flagged when test_value != last_value.
REQ-010 SHALL, on a change edge, load pending <= test_value and set pending_valid.
REQ-011 SHALL, in IDLE with pending_valid set, clear pending_valid, latch pending into the frame buffer, enter START and drive TX low from that same edge.
- Latency: a change sampled at edge k gives a TX falling edge at edge k+1.
REQ-012 SHALL send one frame as 3 bytes in order: 8'hA5 sync byte, test_value[15:8], test_value[7:0].
REQ-013 SHALL encode each byte as 1 start bit (0), 8 data bits LSB first and 1 stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-014 SHALL use states IDLE, START, DATA and STOP.
- IDLE->START on pending_valid.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->STOP after 8 bits.
- STOP->START for the next byte if byte_idx<2.
- STOP->IDLE after byte 2.
REQ-015 SHALL place frames back to back: if pending_valid is set when the last stop bit ends, IDLE lasts exactly one cycle before the next START.
REQ-016 SHALL assert busy in every state except IDLE.
REQ-017 SHALL keep one pending slot; a change while pending_valid is already set overwrites pending (latest wins) and increments dropped_cnt.
REQ-018 SHALL saturate dropped_cnt at 8'hFF.
REQ-019 SHALL, when a change and the IDLE->START take occur on the same edge, transmit the old pending value, store the new value with pending_valid=1 and leave dropped_cnt unchanged.
REQ-020 SHALL transmit the value latched at frame start unchanged, regardless of test_value activity during the frame.
REQ-021 SHALL sample test_value raw; the value SHALL be synchronous to CLK, with no metastability handling.
REQ-022 SHALL support VALUE_WIDTH other than 16 as follows.
- Upper byte = value zero-extended or truncated to 16 bits, bits [15:8].
- Lower byte = bits [7:0].

Reset
REQ-023 SHALL, on RESET low, immediately set the following, independent of CLK.
- TX=1, busy=0, state=IDLE.
- last_value=0, pending=0, pending_valid=0, dropped_cnt=0.
- Bit counter, cycle counter and byte_idx = 0.
REQ-024 SHALL abort any frame in progress on reset; TX returns high with no stop bit.
REQ-025 SHALL not treat a post-reset test_value of 0 as a change; a nonzero value present at reset release IS a change at the first edge.

Structure
REQ-026 SHALL take from shared package riscv_dbg_pkg: SYNC_BYTE=8'hA5, the state enumeration and FRAME_BYTES=3.
REQ-027 SHALL instantiate one sub-module, uart_tx_byte, which does the byte serialization.
- Its handshake is start/byte_in/done.
- The parent holds the change detector, pending slot, byte sequencer and dropped counter.
REQ-028 SHALL size the cycle counter as clog2(CLKS_PER_BIT) bits.

Verification (CLKS_PER_BIT=4)
REQ-029 SHALL check single change: test_value 0->16'h1234 held.
- TX falls 1 cycle after the sampling edge.
- Decoded bytes are A5, 12, 34.
- Frame is 120 cycles; busy is high for exactly 120 cycles.
REQ-030 SHALL check overwrite: during a frame, drive 16'h0001 then 16'h0002 then 16'h0003.
- The next frame carries 0003.
- dropped_cnt=2.
REQ-031 SHALL check back-to-back frames: a change lands during the final stop bit.
- Exactly one IDLE cycle with TX high.
- The second frame starts with A5.
REQ-032 SHALL check the simultaneous take and change edge: no drop counted and both values transmitted in order.
REQ-033 SHALL check reset mid-DATA of byte 1.
- TX=1 and busy=0 immediately.
- After release with test_value unchanged nonzero, a full new frame is sent.
REQ-034 SHALL check saturation: 300 overwrites leave dropped_cnt=8'hFF.
